// File: rtl/uart_rx_pkg.sv
// uart_rx shared types: FSM encoding and bit-period derivation.
// Shared with uart_tx so both ends compute identical bit periods.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } rx_state_t;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int bit_rate
  );
    return clk_freq / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx host-side bundle: received word plus status pulses.
// master = receiver, slave = consumer.
interface uart_rx_if #(
  parameter int PAYLOAD_BITS = 8
);

  logic [PAYLOAD_BITS-1:0] o_data;
  logic                    o_rx_valid;
  logic                    o_frame_err;
  logic                    o_rx_busy;

  modport master (
    output o_data,
    output o_rx_valid,
    output o_frame_err,
    output o_rx_busy
  );

  modport slave (
    input o_data,
    input o_rx_valid,
    input o_frame_err,
    input o_rx_busy
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// RESET_VAL sets the assumed idle level during reset.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, PAYLOAD_BITS data LSB-first, 1 stop.
// Emits one-cycle valid or frame-error pulses per frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_FREQ     = 10_000_000,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_serial_data,
  uart_rx_if.master   rx
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BIT_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int IW   =
    (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_END = IW'(PAYLOAD_BITS - 1);

  generate
    if (CPB < 4) begin : g_cpb_chk
      $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  logic rx_s;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_serial_data),
    .q     (rx_s)
  );

  rx_state_t               state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [PAYLOAD_BITS-1:0] shift, shift_n;
  logic [PAYLOAD_BITS-1:0] data_q, data_n;
  logic                    valid_q, valid_n;
  logic                    err_q, err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data_q;
    valid_n = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == CPB_M1) begin
          cnt_n   = '0;
          // right shift keeps the first bit at LSB
          shift_n = shift >> 1;
          shift_n[PAYLOAD_BITS-1] = rx_s;
          if (idx == IDX_END) begin
            state_n = S_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == CPB_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_WAIT_HI;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign rx.o_data      = data_q;
  assign rx.o_rx_valid  = valid_q;
  assign rx.o_frame_err = err_q;
  assign rx.o_rx_busy   = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx driven by a behavioural line model.
// Pulse monitor runs on the falling clock edge.
module tb_uart_rx;

  localparam int CPB = 86;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int bcnt = 0;
  int vcyc = 0;
  int start_cyc = 0;
  logic [7:0] got[$];

  uart_rx_if #(.PAYLOAD_BITS(8)) rx_bus ();

  uart_rx #(
    .BIT_RATE     (115200),
    .CLK_FREQ     (10_000_000),
    .PAYLOAD_BITS (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_serial_data (line),
    .rx            (rx_bus)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_bus.o_rx_valid) begin
      vcnt = vcnt + 1;
      vcyc = cyc;
      got.push_back(rx_bus.o_data);
    end
    if (rx_bus.o_frame_err) ecnt = ecnt + 1;
    if (rx_bus.o_rx_valid && rx_bus.o_frame_err)
      bcnt = bcnt + 1;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(
    input logic [7:0] d,
    input logic       stop,
    input int         cpb
  );
    start_cyc = cyc;
    drive(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(d[i], cpb);
    drive(stop, cpb);
    line = 1'b1;
  endtask

  function automatic logic [7:0] word(input int k);
    if (k < got.size()) return got[k];
    return 8'hxx;
  endfunction

  function automatic logic lat_ok();
    int lat;
    lat = vcyc - start_cyc;
    return (lat >= 789) && (lat <= 849);
  endfunction

  initial begin
    #100;
    @(negedge clk);
    check("rst_data", 32'(rx_bus.o_data), 0);
    check("rst_valid", 32'(rx_bus.o_rx_valid), 0);
    check("rst_err", 32'(rx_bus.o_frame_err), 0);
    check("rst_busy", 32'(rx_bus.o_rx_busy), 0);
    reset = 1'b0;
    drive(1'b1, 20);

    send(8'h55, 1'b1, CPB);
    send(8'h99, 1'b1, CPB);
    drive(1'b1, 20);
    check("t1_vcnt", vcnt, 2);
    check("t1_w0", 32'(word(0)), 32'h55);
    check("t1_w1", 32'(word(1)), 32'h99);
    check("t1_ecnt", ecnt, 0);

    drive(1'b0, 20);
    drive(1'b1, 100);
    check("t2_busy", 32'(rx_bus.o_rx_busy), 0);
    check("t2_vcnt", vcnt, 2);
    check("t2_ecnt", ecnt, 0);
    check("t2_data", 32'(rx_bus.o_data), 32'h99);

    send(8'hA5, 1'b0, CPB);
    check("t3_ecnt", ecnt, 1);
    check("t3_vcnt", vcnt, 2);
    check("t3_data", 32'(rx_bus.o_data), 32'h99);
    drive(1'b0, 20 * CPB);
    check("t3_hold_busy", 32'(rx_bus.o_rx_busy), 1);
    check("t3_hold_vcnt", vcnt, 2);
    check("t3_hold_ecnt", ecnt, 1);
    drive(1'b1, 200);
    check("t3_idle_busy", 32'(rx_bus.o_rx_busy), 0);
    send(8'h3C, 1'b1, CPB);
    drive(1'b1, 20);
    check("t3_vcnt2", vcnt, 3);
    check("t3_w2", 32'(word(2)), 32'h3C);

    send(8'h00, 1'b1, CPB);
    send(8'hFF, 1'b1, CPB);
    send(8'h81, 1'b1, CPB);
    drive(1'b1, 20);
    check("t4_vcnt", vcnt, 6);
    check("t4_w3", 32'(word(3)), 32'h00);
    check("t4_w4", 32'(word(4)), 32'hFF);
    check("t4_w5", 32'(word(5)), 32'h81);
    check("t4_data", 32'(rx_bus.o_data), 32'h81);

    drive(1'b0, CPB);
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB);
    drive(1'b0, CPB);
    drive(1'b1, 40);
    reset = 1'b1;
    @(negedge clk);
    check("t5_data", 32'(rx_bus.o_data), 0);
    check("t5_valid", 32'(rx_bus.o_rx_valid), 0);
    check("t5_err", 32'(rx_bus.o_frame_err), 0);
    check("t5_busy", 32'(rx_bus.o_rx_busy), 0);
    line = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 200);
    check("t5_vcnt0", vcnt, 6);
    send(8'h12, 1'b1, CPB);
    drive(1'b1, 20);
    check("t5_vcnt", vcnt, 7);
    check("t5_w6", 32'(word(6)), 32'h12);

    send(8'hC3, 1'b1, 89);
    drive(1'b1, 20);
    check("t6_slow_vcnt", vcnt, 8);
    check("t6_slow_w", 32'(word(7)), 32'hC3);
    check("t6_slow_lat", 32'(lat_ok()), 1);
    send(8'hC3, 1'b1, 83);
    drive(1'b1, 20);
    check("t6_fast_vcnt", vcnt, 9);
    check("t6_fast_w", 32'(word(8)), 32'hC3);
    check("t6_fast_lat", 32'(lat_ok()), 1);
    check("t6_ecnt", ecnt, 1);
    check("both_pulses", bcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
